eth_burst_realign: RTL and testbench

- Parametrised byte realigner between an AXI read-data stream fetched from an unaligned byte address and the Ethernet TX buffer path.
- At start it latches byte offset and length and computes the AXI burst length.
- It then consumes input beats and emits a word-aligned output stream with byte strobes and last flag.
- Full valid/ready handshakes on both sides, and a flush beat for residual bytes.

---
 rtl/eth_burst_realign.sv | 228 ++++++++++++++++++++++
 tb/tb_eth_burst_realign.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_burst_realign.sv
// Realigns an AXI read-data stream that starts at an unaligned byte offset into word-aligned beats.
// Build option: define ETH_BURST_REALIGN_ZERO_PAD_EN to force unstrobed output bytes to zero.
module eth_burst_realign #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned LEN_W     = 12,
   parameter int unsigned AXI_LEN_W = 8,
   localparam int unsigned NB       = DATA_W / 8,
   localparam int unsigned OFF_W    = $clog2(NB)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [OFF_W-1:0]     offset,
   input  logic [LEN_W-1:0]     len,
   input  logic [DATA_W-1:0]    in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [DATA_W-1:0]    out_data,
   output logic [NB-1:0]        out_strb,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic [AXI_LEN_W-1:0] axi_len,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned CNT_W = LEN_W + 1;

   typedef enum logic [2:0] {
      StIdle,
      StPrime,
      StStream,
      StFlush,
      StWait
   } state_e;

   state_e               state_q, state_d;
   logic [OFF_W-1:0]     off_q, off_d;
   logic [CNT_W-1:0]     in_cnt_q, in_cnt_d;
   logic [CNT_W-1:0]     out_cnt_q, out_cnt_d;
   logic [DATA_W-1:0]    stored_q, stored_d;
   logic [AXI_LEN_W-1:0] axi_len_q, axi_len_d;
   logic                 flush_q, flush_d;
   logic [NB-1:0]        last_strb_q, last_strb_d;
   logic [DATA_W-1:0]    out_data_q, out_data_d;
   logic [NB-1:0]        out_strb_q, out_strb_d;
   logic                 out_valid_q, out_valid_d;
   logic                 out_last_q, out_last_d;
   logic                 done_q, done_d;

   logic [CNT_W-1:0]     in_beats, out_beats;
   logic [NB-1:0]        rem_strb;
   logic [OFF_W-1:0]     off_neg;
   logic [OFF_W+2:0]     sh_up, sh_dn;
   logic [DATA_W-1:0]    stream_word, stored_next;
   logic                 slot_free, in_fire, beat_last;
   logic [NB-1:0]        beat_strb;

   function automatic logic [DATA_W-1:0] strb_to_mask(input logic [NB-1:0] s);
      logic [DATA_W-1:0] m;
      m = '0;
      for (int i = 0; i < int'(NB); i++) begin
         m[8*i +: 8] = {8{s[i]}};
      end
      return m;
   endfunction

   function automatic logic [DATA_W-1:0] pad_beat(input logic [DATA_W-1:0] d,
                                                  input logic [NB-1:0]     s);
`ifdef ETH_BURST_REALIGN_ZERO_PAD_EN
      return d & strb_to_mask(s);
`else
      logic [NB-1:0] unused_s;
      unused_s = s;
      return d;
`endif
   endfunction

   // Transfer sizing, evaluated from the raw inputs at start.
   always_comb begin
      in_beats  = (CNT_W'(offset) + CNT_W'(len) + CNT_W'(NB - 1)) >> OFF_W;
      out_beats = (CNT_W'(len) + CNT_W'(NB - 1)) >> OFF_W;
      if (len[OFF_W-1:0] == '0) begin
         rem_strb = '1;
      end else begin
         rem_strb = (NB'(1) << len[OFF_W-1:0]) - NB'(1);
      end
   end

   // An output beat splices the low offset bytes of the new input above the bytes held back
   // from the previous input; the upper bytes of the new input are then held back in turn.
   always_comb begin
      off_neg     = '0 - off_q;
      sh_up       = {off_neg, 3'b000};
      sh_dn       = {off_q, 3'b000};
      stored_next = in_data >> sh_dn;
      if (off_q == '0) begin
         stream_word = in_data;
      end else begin
         stream_word = stored_q | (in_data << sh_up);
      end
   end

   assign slot_free = !out_valid_q || out_ready;
   assign in_ready  = (state_q == StPrime) ||
                      ((state_q == StStream) && slot_free && (in_cnt_q != '0));
   assign in_fire   = in_valid && in_ready;
   assign beat_last = (out_cnt_q == CNT_W'(1));
   assign beat_strb = beat_last ? last_strb_q : '1;

   always_comb begin
      state_d     = state_q;
      off_d       = off_q;
      in_cnt_d    = in_cnt_q;
      out_cnt_d   = out_cnt_q;
      stored_d    = stored_q;
      axi_len_d   = axi_len_q;
      flush_d     = flush_q;
      last_strb_d = last_strb_q;
      out_data_d  = out_data_q;
      out_strb_d  = out_strb_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      done_d      = 1'b0;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (len == '0) begin
                  done_d = 1'b1;
               end else begin
                  off_d       = offset;
                  axi_len_d   = AXI_LEN_W'(in_beats - CNT_W'(1));
                  in_cnt_d    = in_beats;
                  out_cnt_d   = out_beats;
                  flush_d     = (offset != '0) && (out_beats == in_beats);
                  last_strb_d = rem_strb;
                  state_d     = (offset != '0) ? StPrime : StStream;
               end
            end
         end
         StPrime: begin
            if (in_fire) begin
               stored_d = stored_next;
               in_cnt_d = in_cnt_q - CNT_W'(1);
               state_d  = (in_cnt_q == CNT_W'(1)) ? StFlush : StStream;
            end
         end
         StStream: begin
            if (in_fire) begin
               stored_d    = stored_next;
               in_cnt_d    = in_cnt_q - CNT_W'(1);
               out_cnt_d   = out_cnt_q - CNT_W'(1);
               out_valid_d = 1'b1;
               out_data_d  = pad_beat(stream_word, beat_strb);
               out_strb_d  = beat_strb;
               out_last_d  = beat_last;
               if (in_cnt_q == CNT_W'(1)) begin
                  state_d = flush_q ? StFlush : StWait;
               end
            end
         end
         StFlush: begin
            if (slot_free) begin
               out_cnt_d   = out_cnt_q - CNT_W'(1);
               out_valid_d = 1'b1;
               out_data_d  = pad_beat(stored_q, beat_strb);
               out_strb_d  = beat_strb;
               out_last_d  = beat_last;
               state_d     = StWait;
            end
         end
         StWait: begin
            if (out_valid_q && out_ready && out_last_q) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         off_q       <= '0;
         in_cnt_q    <= '0;
         out_cnt_q   <= '0;
         stored_q    <= '0;
         axi_len_q   <= '0;
         flush_q     <= 1'b0;
         last_strb_q <= '0;
         out_data_q  <= '0;
         out_strb_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         off_q       <= off_d;
         in_cnt_q    <= in_cnt_d;
         out_cnt_q   <= out_cnt_d;
         stored_q    <= stored_d;
         axi_len_q   <= axi_len_d;
         flush_q     <= flush_d;
         last_strb_q <= last_strb_d;
         out_data_q  <= out_data_d;
         out_strb_q  <= out_strb_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         done_q      <= done_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_strb  = out_strb_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign axi_len   = axi_len_q;
   assign busy      = (state_q != StIdle);
   assign done      = done_q;

endmodule

// File: tb/tb_eth_burst_realign.sv
// Directed, table-driven bench for eth_burst_realign at DATA_W=32.
module tb_eth_burst_realign;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  offset;
   logic [11:0] len;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_data;
   logic [3:0]  out_strb;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic [7:0]  axi_len;
   logic        busy;
   logic        done;

   int checks   = 0;
   int failures = 0;

   eth_burst_realign #(
      .DATA_W   (32),
      .LEN_W    (12),
      .AXI_LEN_W(8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .offset   (offset),
      .len      (len),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_data (out_data),
      .out_strb (out_strb),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_last (out_last),
      .axi_len  (axi_len),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]       off;
      logic [11:0]      len;
      logic [1:0]       n_in;
      logic [2:0][31:0] in_w;
      logic [7:0]       axi;
      logic [1:0]       n_out;
      logic [2:0][31:0] out_w;
      logic [2:0][3:0]  strb;
      logic [2:0]       stall;
      logic [3:0]       restart;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] bmask(input logic [3:0] s);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{s[i]}};
      return m;
   endfunction

   function automatic vec_t mk(input logic [1:0] off, input logic [11:0] l, input logic [1:0] n_in,
                               input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] i2,
                               input logic [7:0] axi, input logic [1:0] n_out,
                               input logic [31:0] o0, input logic [31:0] o1, input logic [31:0] o2,
                               input logic [3:0] s0, input logic [3:0] s1,
                               input logic [2:0] stall, input logic [3:0] restart);
      vec_t v;
      v.off     = off;
      v.len     = l;
      v.n_in    = n_in;
      v.in_w[0] = i0;
      v.in_w[1] = i1;
      v.in_w[2] = i2;
      v.axi     = axi;
      v.n_out   = n_out;
      v.out_w[0] = o0;
      v.out_w[1] = o1;
      v.out_w[2] = o2;
      v.strb[0] = s0;
      v.strb[1] = s1;
      v.strb[2] = 4'h0;
      v.stall   = stall;
      v.restart = restart;
      return v;
   endfunction

   // Runs one transfer; extra input words (0xDEADBEEF) are offered to catch over-acceptance.
   task automatic run_vec(input vec_t v, input string tag);
      int  n_got = 0;
      int  n_acc = 0;
      int  stall_left = 0;
      bit  stalled = 0;
      bit  done_seen = 0;
      bit  last_fire = 0;
      bit  prev_last;
      @(posedge clk); #1;
      start = 1'b1; offset = v.off; len = v.len; in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         if (cyc == 0) chk({tag, "_axi_len"}, 32'(axi_len), 32'(v.axi));
         prev_last = last_fire;
         last_fire = 0;
         if (prev_last || done) begin
            chk({tag, "_done_timing"}, {30'd0, prev_last, done}, 32'd3);
            chk({tag, "_busy_clear"}, 32'(busy), 32'd0);
            done_seen = 1;
            break;
         end
         if (v.restart != 0 && cyc == int'(v.restart)) begin
            start = 1'b1; offset = 2'd0; len = 12'd4;
         end else begin
            start = 1'b0;
         end
         in_valid = 1'b1;
         in_data  = (n_acc < int'(v.n_in)) ? v.in_w[n_acc] : 32'hDEADBEEF;
         if (out_valid && !stalled && v.stall != 0) begin
            stalled    = 1;
            stall_left = int'(v.stall);
         end
         out_ready = (stall_left == 0);
         #2;
         if (stall_left > 0) begin
            chk({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
            chk({tag, "_stall_hold"}, out_data & bmask(out_strb),
                v.out_w[n_got] & bmask(v.strb[n_got]));
            stall_left--;
         end
         if (in_valid && in_ready) n_acc++;
         if (out_valid && out_ready) begin
            if (n_got < int'(v.n_out)) begin
               chk({tag, "_data"}, out_data & bmask(out_strb),
                   v.out_w[n_got] & bmask(v.strb[n_got]));
               chk({tag, "_strb"}, 32'(out_strb), 32'(v.strb[n_got]));
               chk({tag, "_last"}, 32'(out_last), 32'(n_got == int'(v.n_out) - 1));
            end
            if (out_last) last_fire = 1;
            n_got++;
         end
         @(posedge clk); #1;
      end
      start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      chk({tag, "_completed"}, 32'(done_seen), 32'd1);
      chk({tag, "_out_count"}, 32'(n_got), 32'(v.n_out));
      chk({tag, "_in_count"}, 32'(n_acc), 32'(v.n_in));
      chk({tag, "_axi_len_hold"}, 32'(axi_len), 32'(v.axi));
      @(posedge clk); #1;
      chk({tag, "_done_one_cycle"}, {30'd0, done, busy}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; offset = '0; len = '0;
      in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
      #3;
      chk("reset_ctrl", {23'd0, in_ready, out_valid, out_last, busy, done, out_strb}, 32'd0);
      chk("reset_data", out_data, 32'd0);
      chk("reset_axi_len", 32'(axi_len), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      vecs[0] = mk(2'd0, 12'd8, 2'd2, 32'h03020100, 32'h07060504, 32'h0, 8'd1, 2'd2,
                   32'h03020100, 32'h07060504, 32'h0, 4'hF, 4'hF, 3'd0, 4'd0);
      vecs[1] = mk(2'd1, 12'd8, 2'd3, 32'h03020100, 32'h07060504, 32'h0B0A0908, 8'd2, 2'd2,
                   32'h04030201, 32'h08070605, 32'h0, 4'hF, 4'hF, 3'd0, 4'd0);
      vecs[2] = mk(2'd1, 12'd3, 2'd1, 32'h03020100, 32'h0, 32'h0, 8'd0, 2'd1,
                   32'h00030201, 32'h0, 32'h0, 4'h7, 4'h0, 3'd0, 4'd0);
      vecs[3] = mk(2'd1, 12'd8, 2'd3, 32'h03020100, 32'h07060504, 32'h0B0A0908, 8'd2, 2'd2,
                   32'h04030201, 32'h08070605, 32'h0, 4'hF, 4'hF, 3'd3, 4'd0);
      vecs[4] = mk(2'd1, 12'd8, 2'd3, 32'h03020100, 32'h07060504, 32'h0B0A0908, 8'd2, 2'd2,
                   32'h04030201, 32'h08070605, 32'h0, 4'hF, 4'hF, 3'd0, 4'd1);
      vecs[5] = mk(2'd1, 12'd7, 2'd2, 32'h03020100, 32'h07060504, 32'h0, 8'd1, 2'd2,
                   32'h04030201, 32'h00070605, 32'h0, 4'hF, 4'h7, 3'd0, 4'd0);
      vecs[6] = mk(2'd2, 12'd4, 2'd2, 32'h03020100, 32'h07060504, 32'h0, 8'd1, 2'd1,
                   32'h05040302, 32'h0, 32'h0, 4'hF, 4'h0, 3'd0, 4'd0);
      vecs[7] = mk(2'd3, 12'd5, 2'd2, 32'h03020100, 32'h07060504, 32'h0, 8'd1, 2'd2,
                   32'h06050403, 32'h00000007, 32'h0, 4'hF, 4'h1, 3'd0, 4'd0);
      vecs[8] = mk(2'd0, 12'd6, 2'd2, 32'h03020100, 32'h07060504, 32'h0, 8'd1, 2'd2,
                   32'h03020100, 32'h00000504, 32'h0, 4'hF, 4'h3, 3'd2, 4'd0);
      vecs[9] = mk(2'd0, 12'd4, 2'd1, 32'hAABBCCDD, 32'h0, 32'h0, 8'd0, 2'd1,
                   32'hAABBCCDD, 32'h0, 32'h0, 4'hF, 4'h0, 3'd0, 4'd0);

      for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // len=0: no busy, done on the following cycle only.
      @(posedge clk); #1;
      start = 1'b1; offset = 2'd1; len = 12'd0;
      @(posedge clk); #1;
      start = 1'b0;
      chk("len0_done", {30'd0, done, busy}, 32'd2);
      @(posedge clk); #1;
      chk("len0_done_clear", {30'd0, done, busy}, 32'd0);

      // offset=0 latency: output valid the cycle after the single input accept.
      @(posedge clk); #1;
      start = 1'b1; offset = 2'd0; len = 12'd4; out_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b1; in_data = 32'h11223344;
      #2;
      chk("lat0_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("lat0_out_valid", {29'd0, out_valid, out_last, busy}, 32'd7);
      chk("lat0_data", out_data, 32'h11223344);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("lat0_done", {30'd0, done, out_valid}, 32'd2);

      // Reset in the middle of a transfer aborts it immediately.
      @(posedge clk); #1;
      start = 1'b1; offset = 2'd1; len = 12'd8;
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b1; in_data = 32'h03020100;
      @(posedge clk); #1;
      in_data = 32'h07060504;
      @(posedge clk); #1;
      chk("mid_pre_rst_valid", 32'(out_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_ctrl", {23'd0, in_ready, out_valid, out_last, busy, done, out_strb}, 32'd0);
      chk("mid_rst_data", out_data, 32'd0);
      chk("mid_rst_axi_len", 32'(axi_len), 32'd0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_rst_no_done", {30'd0, done, busy}, 32'd0);
      run_vec(vecs[9], "after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
